// File: rtl/hf_mode_sequencer_pkg.sv
// Shared command opcodes, major-mode encodings and sequencer types for the
// HF mode sequencer.
package hf_mode_sequencer_pkg;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG   = 4'h1;
  localparam logic [3:0] FPGA_CMD_TRACE_ENABLE  = 4'h2;

  localparam logic [2:0] FPGA_MAJOR_MODE_HF_READER_TX       = 3'd0;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_READER_RX_XCORR = 3'd1;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_SIMULATOR       = 3'd2;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_ISO14443A       = 3'd3;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_SNIFF           = 3'd4;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_GET_TRACE       = 3'd5;
  localparam logic [2:0] FPGA_MAJOR_MODE_OFF                = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_SWITCH,
    ST_SETTLE
  } state_e;

  typedef struct packed {
    logic [2:0] major;
    logic [1:0] sub;
    logic [3:0] minor;
  } mode_cfg_t;

  function automatic mode_cfg_t cmd_to_cfg(input logic [15:0] cmd_word);
    mode_cfg_t cfg;
    cfg.major = cmd_word[8:6];
    cfg.sub   = cmd_word[5:4];
    cfg.minor = cmd_word[3:0];
    return cfg;
  endfunction

endpackage

// File: rtl/hf_mode_sequencer.sv
// Sequences major-mode changes of the HF front end: coil driver is gated
// before the select changes and ADC samples are gated while the new mode settles.
module hf_mode_sequencer
  import hf_mode_sequencer_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic        ck_1356meg,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [15:0] cmd,
  output logic [2:0]  major_mode,
  output logic [3:0]  minor_mode,
  output logic [1:0]  subcarrier_frequency,
  output logic        trace_enable,
  output logic        drv_gate,
  output logic        adc_gate,
  output logic        busy,
  output logic        mode_done
);

  localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e    r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_major, w_major_nxt;
  logic [3:0] r_minor, w_minor_nxt;
  logic [1:0] r_sub, w_sub_nxt;
  logic       r_trace, w_trace_nxt;
  logic       r_drv, w_drv_nxt;
  logic       r_adc, w_adc_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  mode_cfg_t  r_pend, w_pend_nxt;
  logic       r_pend_valid, w_pend_valid_nxt;
  mode_cfg_t  r_tgt, w_tgt_nxt;

  logic      w_is_set, w_is_trace, w_req_valid, w_dispatch;
  mode_cfg_t w_cmd_cfg, w_req;
  logic      w_unused_cmd;

  assign w_is_set    = cmd_valid && (cmd[15:12] == FPGA_CMD_SET_CONFREG);
  assign w_is_trace  = cmd_valid && (cmd[15:12] == FPGA_CMD_TRACE_ENABLE);
  assign w_cmd_cfg   = cmd_to_cfg(cmd);
  // A command arriving on the decision cycle outranks the buffered one.
  assign w_req_valid = w_is_set || r_pend_valid;
  assign w_req       = w_is_set ? w_cmd_cfg : r_pend;
  assign w_unused_cmd = ^cmd[11:9];

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_major_nxt      = r_major;
    w_minor_nxt      = r_minor;
    w_sub_nxt        = r_sub;
    w_trace_nxt      = r_trace;
    w_drv_nxt        = r_drv;
    w_adc_nxt        = r_adc;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_pend_nxt       = r_pend;
    w_pend_valid_nxt = r_pend_valid;
    w_tgt_nxt        = r_tgt;
    w_dispatch       = 1'b0;

    if (w_is_trace) w_trace_nxt = cmd[0];
    if (w_is_set && (r_state != ST_IDLE)) begin
      w_pend_nxt       = w_cmd_cfg;
      w_pend_valid_nxt = 1'b1;
    end

    unique case (r_state)
      ST_IDLE: w_dispatch = w_req_valid;
      ST_GATE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_SWITCH;
          w_major_nxt = r_tgt.major;
          w_minor_nxt = r_tgt.minor;
          w_sub_nxt   = r_tgt.sub;
          w_adc_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_SWITCH: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = SETTLE_LOAD;
        w_drv_nxt   = (r_major == FPGA_MAJOR_MODE_OFF);
      end
      ST_SETTLE: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_adc_nxt   = (r_major == FPGA_MAJOR_MODE_OFF);
          w_dispatch  = w_req_valid;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Same major applies in place; a different major (re)starts the guard.
    if (w_dispatch) begin
      w_pend_valid_nxt = 1'b0;
      if (w_req.major == r_major) begin
        w_minor_nxt = w_req.minor;
        w_sub_nxt   = w_req.sub;
      end else begin
        w_state_nxt = ST_GATE;
        w_tgt_nxt   = w_req;
        w_cnt_nxt   = GUARD_LOAD;
        w_drv_nxt   = 1'b1;
        w_busy_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      // NOTE: reset parks the front end in OFF with both gates closed.
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_major      <= FPGA_MAJOR_MODE_OFF;
      r_minor      <= 4'd0;
      r_sub        <= 2'd0;
      r_trace      <= 1'b0;
      r_drv        <= 1'b1;
      r_adc        <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_tgt        <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_major      <= w_major_nxt;
      r_minor      <= w_minor_nxt;
      r_sub        <= w_sub_nxt;
      r_trace      <= w_trace_nxt;
      r_drv        <= w_drv_nxt;
      r_adc        <= w_adc_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_tgt        <= w_tgt_nxt;
    end
  end

  assign major_mode           = r_major;
  assign minor_mode           = r_minor;
  assign subcarrier_frequency = r_sub;
  assign trace_enable         = r_trace;
  assign drv_gate             = r_drv;
  assign adc_gate             = r_adc;
  assign busy                 = r_busy;
  assign mode_done            = r_done;

endmodule

// File: tb/tb_hf_mode_sequencer.sv
// Scoreboard bench: stimulus queues the hand-timed output changes it expects,
// a negedge monitor pops one entry for every observed change of the outputs.
module tb_hf_mode_sequencer;

  typedef struct packed {
    logic [2:0] major;
    logic [3:0] minor;
    logic [1:0] sub;
    logic       trace;
    logic       drv;
    logic       adc;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    int    cyc;
    out_t  v;
    string name;
  } exp_t;

  localparam out_t RESET_VEC = '{major: 3'd7, minor: 4'd0, sub: 2'd0, trace: 1'b0,
                                 drv: 1'b1, adc: 1'b1, busy: 1'b0, done: 1'b0};

  logic        ck_1356meg = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [15:0] cmd;
  logic [2:0]  major_mode;
  logic [3:0]  minor_mode;
  logic [1:0]  subcarrier_frequency;
  logic        trace_enable, drv_gate, adc_gate, busy, mode_done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   e_last;
  logic mon_en = 1'b0;
  logic prev_valid = 1'b0;
  out_t prev;
  out_t m;
  exp_t exp_q[$];
  exp_t got_e;

  hf_mode_sequencer #(.GUARD_CYCLES(16), .SETTLE_CYCLES(64)) dut (
    .ck_1356meg           (ck_1356meg),
    .reset                (reset),
    .cmd_valid            (cmd_valid),
    .cmd                  (cmd),
    .major_mode           (major_mode),
    .minor_mode           (minor_mode),
    .subcarrier_frequency (subcarrier_frequency),
    .trace_enable         (trace_enable),
    .drv_gate             (drv_gate),
    .adc_gate             (adc_gate),
    .busy                 (busy),
    .mode_done            (mode_done)
  );

  always #5 ck_1356meg = ~ck_1356meg;
  always @(posedge ck_1356meg) cyc <= cyc + 1;

  function automatic out_t sample();
    out_t s;
    s.major = major_mode;
    s.minor = minor_mode;
    s.sub   = subcarrier_frequency;
    s.trace = trace_enable;
    s.drv   = drv_gate;
    s.adc   = adc_gate;
    s.busy  = busy;
    s.done  = mode_done;
    return s;
  endfunction

  // Monitor: every change of the output vector must match the next expectation.
  always @(negedge ck_1356meg) begin : monitor
    out_t cur;
    cur = sample();
    if (!mon_en) begin
      prev_valid = 1'b0;
    end else if (!prev_valid) begin
      prev       = cur;
      prev_valid = 1'b1;
    end else if (cur != prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h prev=%h want=no change", cyc, cur, prev);
      end else begin
        got_e = exp_q.pop_front();
        if (got_e.cyc != cyc || got_e.v != cur) begin
          errors++;
          $display("FAIL %s: got cyc=%0d vec=%h, want cyc=%0d vec=%h",
                   got_e.name, cyc, cur, got_e.cyc, got_e.v);
        end
      end
      prev = cur;
    end
  end

  task automatic check(input string name, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic expect_at(input int c, input string name);
    exp_t e;
    e.cyc  = c;
    e.v    = m;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic cmd_at(input logic [15:0] c);
    @(negedge ck_1356meg);
    cmd       = c;
    cmd_valid = 1'b1;
    e_last    = cyc + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge ck_1356meg);
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    int e;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 16'h0000;
    repeat (3) @(negedge ck_1356meg);
    check("reset_values", sample(), RESET_VEC);
    reset  = 1'b0;
    mon_en = 1'b1;
    m      = RESET_VEC;
    tick(2);

    // OFF -> mode 0: 16 guard cycles, SWITCH, 64 settle cycles.
    cmd_at(16'h1000); e = e_last;
    m.busy = 1'b1;                                   expect_at(e,      "a_gate");
    m.major = 3'd0;                                  expect_at(e + 16, "a_switch");
    m.drv = 1'b0;                                    expect_at(e + 17, "a_settle");
    m.adc = 1'b0; m.busy = 1'b0; m.done = 1'b1;      expect_at(e + 81, "a_done");
    m.done = 1'b0;                                   expect_at(e + 82, "a_done_end");
    tick(90);

    // Same major: minor applied next cycle, no gating.
    cmd_at(16'h1005); e = e_last;
    m.minor = 4'd5;                                  expect_at(e,      "b_minor");
    tick(4);

    // To mode 2; mode 3 then mode 4 requested during GATE: 4 wins, back to back.
    cmd_at(16'h1093); e = e_last;
    m.drv = 1'b1; m.busy = 1'b1;                     expect_at(e,      "c_gate2");
    m.major = 3'd2; m.sub = 2'd1; m.minor = 4'd3; m.adc = 1'b1;
                                                     expect_at(e + 16, "c_switch2");
    m.drv = 1'b0;                                    expect_at(e + 17, "c_settle2");
    m.adc = 1'b0; m.done = 1'b1; m.drv = 1'b1;       expect_at(e + 81, "c_done2_gate4");
    m.done = 1'b0;                                   expect_at(e + 82, "c_done2_end");
    m.major = 3'd4; m.sub = 2'd2; m.minor = 4'd9; m.adc = 1'b1;
                                                     expect_at(e + 97, "c_switch4");
    m.drv = 1'b0;                                    expect_at(e + 98, "c_settle4");
    m.adc = 1'b0; m.busy = 1'b0; m.done = 1'b1;      expect_at(e + 162, "c_done4");
    m.done = 1'b0;                                   expect_at(e + 163, "c_done4_end");
    tick(2);
    cmd_at(16'h10C0);
    tick(2);
    cmd_at(16'h1129);
    tick(170);

    // To mode 1 with a trace enable arriving mid-SETTLE.
    cmd_at(16'h1040); e = e_last;
    m.drv = 1'b1; m.busy = 1'b1;                     expect_at(e,      "d_gate");
    m.major = 3'd1; m.sub = 2'd0; m.minor = 4'd0; m.adc = 1'b1;
                                                     expect_at(e + 16, "d_switch");
    m.drv = 1'b0;                                    expect_at(e + 17, "d_settle");
    m.trace = 1'b1;                                  expect_at(e + 40, "d_trace");
    m.adc = 1'b0; m.busy = 1'b0; m.done = 1'b1;      expect_at(e + 81, "d_done");
    m.done = 1'b0;                                   expect_at(e + 82, "d_done_end");
    tick(39);
    cmd_at(16'h2001);
    tick(50);

    // To OFF: both gates stay closed after SETTLE; unknown opcode is ignored.
    cmd_at(16'h11C0); e = e_last;
    m.drv = 1'b1; m.busy = 1'b1;                     expect_at(e,      "e_gate");
    m.major = 3'd7; m.adc = 1'b1;                    expect_at(e + 16, "e_switch");
    m.busy = 1'b0; m.done = 1'b1;                    expect_at(e + 81, "e_done");
    m.done = 1'b0;                                   expect_at(e + 82, "e_done_end");
    tick(90);
    cmd_at(16'hF1C5);
    tick(10);

    // Reset in the 5th GATE cycle abandons the transition.
    cmd_at(16'h1080); e = e_last;
    m.busy = 1'b1;                                   expect_at(e,      "f_gate");
    tick(5);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("f_async_reset", sample(), RESET_VEC);
    @(negedge ck_1356meg);
    reset  = 1'b0;
    mon_en = 1'b1;
    m      = RESET_VEC;
    tick(120);
    check("f_no_transition", sample(), RESET_VEC);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got=%0d left, want=0 (next %s at cyc %0d)",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
